ram_1r1w_pipe: RTL

Parametrised simple-dual-port synchronous RAM with byte-strobed writes, a valid/ready read-request port, a valid/ready read-response port with backpressure, a selectable read-during-write policy, and an optional extra output pipeline stage. It is the general-purpose storage macro for the core: register-file banks, cache data/tag arrays and buffers that must tolerate a stalled consumer without dropping read data.

---
 rtl/ram_1r1w_pipe.sv | 89 ++++++++
 1 files changed

// File: rtl/ram_1r1w_pipe.sv
// ram_1r1w_pipe: simple-dual-port RAM with byte strobes, valid/ready read ports, optional output stage
module ram_1r1w_pipe #(
    parameter int Width     = 32,
    parameter int Depth     = 256,
    parameter int ByteWidth = 8,
    parameter int BypassEn  = 1,
    parameter int OutReg    = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       w_en_i,
    input  logic [$clog2(Depth)-1:0]   waddr_i,
    input  logic [Width-1:0]           wdata_i,
    input  logic [Width/ByteWidth-1:0] wstrb_i,
    input  logic                       r_valid_i,
    output logic                       r_ready_o,
    input  logic [$clog2(Depth)-1:0]   raddr_i,
    output logic                       rdata_valid_o,
    input  logic                       rdata_ready_i,
    output logic [Width-1:0]           rdata_o
);
    localparam int Lanes = Width / ByteWidth;
    localparam int Lat   = (OutReg != 0) ? 2 : 1;
    localparam int Cap   = Lat + 1;
    localparam int Cw    = $clog2(Cap + 1);
    localparam int Pw    = $clog2(Cap);
    logic [Width-1:0] mem [Depth];
    logic [Width-1:0] fifo [Cap];
    logic [Width-1:0] rd_word, push_data;
    logic [Pw-1:0]    wptr, rptr;
    logic [Cw-1:0]    count, outstanding;
    logic             accept, pop, push;
    assign r_ready_o     = rst_ni && (outstanding < Cw'(Cap));
    assign accept        = r_valid_i && r_ready_o;
    assign rdata_valid_o = count != '0;
    assign pop           = rdata_valid_o && rdata_ready_i;
    assign rdata_o       = fifo[rptr];
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_en_i && 32'(waddr_i) < Depth)
            for (int k = 0; k < Lanes; k++)
                if (wstrb_i[k])
                    mem[waddr_i][k*ByteWidth +: ByteWidth] <= wdata_i[k*ByteWidth +: ByteWidth];
    end
    always_comb begin
        rd_word = '0;
        if (32'(raddr_i) < Depth)
            for (int k = 0; k < Lanes; k++)
                rd_word[k*ByteWidth +: ByteWidth] =
                    (BypassEn != 0 && w_en_i && waddr_i == raddr_i && wstrb_i[k]) ?
                    wdata_i[k*ByteWidth +: ByteWidth] : mem[raddr_i][k*ByteWidth +: ByteWidth];
    end
    generate
        if (OutReg != 0) begin : g_out_reg
            logic             s1_v;
            logic [Width-1:0] s1_d;
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    s1_v <= 1'b0;
                    s1_d <= '0;
                end else begin
                    s1_v <= accept;
                    s1_d <= rd_word;
                end
            end
            assign push      = s1_v;
            assign push_data = s1_d;
        end else begin : g_direct
            assign push      = accept;
            assign push_data = rd_word;
        end
    endgenerate
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            outstanding <= '0;
            for (int i = 0; i < Cap; i++) fifo[i] <= '0;
        end else begin
            if (push) begin
                fifo[wptr] <= push_data;
                wptr       <= (wptr == Pw'(Cap - 1)) ? '0 : wptr + 1'b1;
            end
            if (pop) rptr <= (rptr == Pw'(Cap - 1)) ? '0 : rptr + 1'b1;
            count       <= count + Cw'(push) - Cw'(pop);
            outstanding <= outstanding + Cw'(accept) - Cw'(pop);
        end
    end
endmodule
